vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator (frame counter: VGA_TIMING_FRAME_CNT_EN)
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int HW       = 10,
    parameter int VW       = 10,
    parameter int FCW      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_en,
    input  logic           restart,
    output logic [HW-1:0]  hpos,
    output logic [VW-1:0]  vpos,
    output logic           de,
    output logic           hsync,
    output logic           vsync,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);

    localparam logic [31:0] H_TOTAL  = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [31:0] V_TOTAL  = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [31:0] H_VIS    = 32'(H_ACTIVE);
    localparam logic [31:0] V_VIS    = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 32'd1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 32'd1);

    if ((64'(H_TOTAL) > (64'd1 << HW)) || (64'(V_TOTAL) > (64'd1 << VW))
        || (H_SYNC == 0) || (V_SYNC == 0)) begin : g_param_err
        $error("vga_timing_gen: counter width too narrow or zero sync width");
    end

    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          load;
    logic          de_nxt;
    logic          hs_act;
    logic          vs_act;

    // Next raster position; restart overrides the pixel enable.
    always_comb begin
        h_nxt = hpos;
        v_nxt = vpos;
        load  = restart || pix_en;
        if (restart) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (pix_en) begin
            if (hpos == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vpos == V_LAST) ? '0 : vpos + 1'b1;
            end else begin
                h_nxt = hpos + 1'b1;
            end
        end
    end

    // Decode from the next position so outputs never lag the counters.
    always_comb begin
        de_nxt = (32'(h_nxt) < H_VIS) && (32'(v_nxt) < V_VIS);
        hs_act = (32'(h_nxt) >= HS_START) && (32'(h_nxt) < HS_END);
        vs_act = (32'(v_nxt) >= VS_START) && (32'(v_nxt) < VS_END);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos        <= '0;
            vpos        <= '0;
            de          <= 1'b1;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else if (load) begin
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            de          <= de_nxt;
            hsync       <= hs_act ? HS_POL : ~HS_POL;
            vsync       <= vs_act ? VS_POL : ~VS_POL;
            line_start  <= (h_nxt == '0);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FCW-1:0] frame_cnt_q;
    logic           frame_wrap;

    assign frame_wrap = !restart && pix_en && (hpos == H_LAST) && (vpos == V_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule
